// File: rtl/issue_raster_positioner_if.sv
// rtl/issue_raster_positioner_if.sv - placement handshake bundle between the raster positioner and the allocators
interface issue_raster_positioner_if #(
    parameter int COORD_W = 8,
    parameter int IDX_W   = 8
);
    logic               alloc_valid;
    logic               alloc_stall;
    logic [COORD_W-1:0] center_x;
    logic [COORD_W-1:0] center_y;
    logic [IDX_W-1:0]   alloc_index;

    modport master (
        output alloc_valid,
        output center_x,
        output center_y,
        output alloc_index,
        input  alloc_stall
    );

    modport slave (
        input  alloc_valid,
        input  center_x,
        input  center_y,
        input  alloc_index,
        output alloc_stall
    );
endinterface

// File: rtl/issue_raster_positioner.sv
// rtl/issue_raster_positioner.sv - raster-order filter centre walker that places allocators per round and tracks the round bounding box
// Optional one-hot allocator select output: define POSITIONER_ONEHOT_SELECT_EN.
module issue_raster_positioner #(
    parameter int NUM_ALLOC = 220,
    parameter int COORD_W   = 8,
    parameter int IDX_W     = 8,
    parameter int PAD_W     = 2,
    parameter int STRIDE_W  = 3,
    parameter int RCNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_load,
    input  logic [COORD_W-1:0]   image_w,
    input  logic [COORD_W-1:0]   image_h,
    input  logic [PAD_W-1:0]     padding,
    input  logic [STRIDE_W-1:0]  stride_x,
    input  logic [STRIDE_W-1:0]  stride_y,
    input  logic                 advance,
    issue_raster_positioner_if.master place,
    output logic [COORD_W-1:0]   x_min,
    output logic [COORD_W-1:0]   x_max,
    output logic [COORD_W-1:0]   y_min,
    output logic [COORD_W-1:0]   y_max,
    output logic                 round_active,
    output logic                 round_done,
    output logic                 layer_done,
    output logic [RCNT_W-1:0]    round_count
`ifdef POSITIONER_ONEHOT_SELECT_EN
    ,
    output logic [NUM_ALLOC-1:0] alloc_select
`endif
);
    localparam int CW1 = COORD_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ALLOC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PLACE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t              state;
    logic [COORD_W-1:0]  cfg_w;
    logic [COORD_W-1:0]  cfg_h;
    logic [PAD_W-1:0]    cfg_p;
    logic [STRIDE_W-1:0] cfg_sx;
    logic [STRIDE_W-1:0] cfg_sy;

    logic [CW1-1:0]      step_x, step_y, pad_ext, x_lim, y_lim, next_x, next_y;
    logic [COORD_W-1:0]  lo_x, hi_x, lo_y, hi_y;
    logic                wrap_x, last_pos, accept, round_end;

    // Next-position and footprint arithmetic is one bit wider so the limit compare never wraps.
    always_comb begin
        step_x    = (cfg_sx == '0) ? CW1'(1) : CW1'(cfg_sx);
        step_y    = (cfg_sy == '0) ? CW1'(1) : CW1'(cfg_sy);
        pad_ext   = CW1'(cfg_p);
        x_lim     = pad_ext + CW1'(cfg_w) - CW1'(1);
        y_lim     = pad_ext + CW1'(cfg_h) - CW1'(1);
        next_x    = CW1'(place.center_x) + step_x;
        next_y    = CW1'(place.center_y) + step_y;
        wrap_x    = next_x > x_lim;
        last_pos  = wrap_x && (next_y > y_lim);
        lo_x      = COORD_W'(CW1'(place.center_x) - pad_ext);
        hi_x      = COORD_W'(CW1'(place.center_x) + pad_ext);
        lo_y      = COORD_W'(CW1'(place.center_y) - pad_ext);
        hi_y      = COORD_W'(CW1'(place.center_y) + pad_ext);
        accept    = (state == S_PLACE) && place.alloc_valid && !place.alloc_stall;
        round_end = accept && ((place.alloc_index == LAST_IDX) || last_pos);
    end

    assign round_active = (state == S_PLACE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= S_IDLE;
            cfg_w             <= '0;
            cfg_h             <= '0;
            cfg_p             <= '0;
            cfg_sx            <= '0;
            cfg_sy            <= '0;
            place.center_x    <= '0;
            place.center_y    <= '0;
            place.alloc_index <= '0;
            place.alloc_valid <= 1'b0;
            round_done        <= 1'b0;
            layer_done        <= 1'b0;
            x_min             <= '1;
            x_max             <= '0;
            y_min             <= '1;
            y_max             <= '0;
            round_count       <= '0;
        end else if (cfg_load) begin
            state             <= S_IDLE;
            cfg_w             <= image_w;
            cfg_h             <= image_h;
            cfg_p             <= padding;
            cfg_sx            <= stride_x;
            cfg_sy            <= stride_y;
            place.center_x    <= COORD_W'(padding);
            place.center_y    <= COORD_W'(padding);
            place.alloc_index <= '0;
            place.alloc_valid <= 1'b0;
            round_done        <= 1'b0;
            layer_done        <= 1'b0;
            x_min             <= '1;
            x_max             <= '0;
            y_min             <= '1;
            y_max             <= '0;
            round_count       <= '0;
        end else begin
            round_done <= 1'b0;
            case (state)
                S_IDLE, S_WAIT: begin
                    if (advance) begin
                        if (cfg_w == '0 || cfg_h == '0) begin
                            state      <= S_DONE;
                            layer_done <= 1'b1;
                        end else begin
                            state             <= S_PLACE;
                            place.alloc_valid <= 1'b1;
                            place.alloc_index <= '0;
                            x_min             <= '1;
                            x_max             <= '0;
                            y_min             <= '1;
                            y_max             <= '0;
                        end
                    end
                end
                S_PLACE: begin
                    if (accept) begin
                        if (lo_x < x_min) x_min <= lo_x;
                        if (hi_x > x_max) x_max <= hi_x;
                        if (lo_y < y_min) y_min <= lo_y;
                        if (hi_y > y_max) y_max <= hi_y;
                        place.alloc_index <= place.alloc_index + IDX_W'(1);
                        // The final position stays on the outputs rather than stepping off the image.
                        if (!last_pos) begin
                            if (wrap_x) begin
                                place.center_x <= COORD_W'(cfg_p);
                                place.center_y <= COORD_W'(next_y);
                            end else begin
                                place.center_x <= COORD_W'(next_x);
                            end
                        end
                    end
                    if (round_end) begin
                        state             <= last_pos ? S_DONE : S_WAIT;
                        place.alloc_valid <= 1'b0;
                        round_done        <= 1'b1;
                        round_count       <= round_count + RCNT_W'(1);
                        layer_done        <= last_pos;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef POSITIONER_ONEHOT_SELECT_EN
    always_comb begin
        alloc_select = '0;
        if (place.alloc_valid && !place.alloc_stall)
            alloc_select = NUM_ALLOC'(1) << place.alloc_index;
    end
`endif

endmodule

// File: tb/tb_issue_raster_positioner.sv
// tb/tb_issue_raster_positioner.sv - randomized bench for issue_raster_positioner against a position-list reference model
module tb_issue_raster_positioner;
    localparam int NA = 8;
    localparam int CW = 8;
    localparam int IW = 3;
    localparam int PW = 2;
    localparam int SW = 3;
    localparam int RW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_load;
    logic          advance;
    logic [CW-1:0] image_w, image_h;
    logic [PW-1:0] padding;
    logic [SW-1:0] stride_x, stride_y;
    logic [CW-1:0] x_min, x_max, y_min, y_max;
    logic          round_active, round_done, layer_done;
    logic [RW-1:0] round_count;
`ifdef POSITIONER_ONEHOT_SELECT_EN
    logic [NA-1:0] alloc_select;
`endif

    issue_raster_positioner_if #(.COORD_W(CW), .IDX_W(IW)) pif();

    issue_raster_positioner #(
        .NUM_ALLOC(NA), .COORD_W(CW), .IDX_W(IW), .PAD_W(PW), .STRIDE_W(SW), .RCNT_W(RW)
    ) u_dut (
        .clk(clk), .rst(rst), .cfg_load(cfg_load),
        .image_w(image_w), .image_h(image_h), .padding(padding),
        .stride_x(stride_x), .stride_y(stride_y), .advance(advance),
        .place(pif),
        .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max),
        .round_active(round_active), .round_done(round_done),
        .layer_done(layer_done), .round_count(round_count)
`ifdef POSITIONER_ONEHOT_SELECT_EN
        , .alloc_select(alloc_select)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int qx[$];
    int qy[$];
    int cur_p;
    int exp_rc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, expv, $time);
        end
    endtask

    // Expected placement order: the full raster list of centres for the loaded config.
    task automatic build_model(input int w, input int h, input int p, input int sx, input int sy);
        int sxe, sye;
        qx.delete();
        qy.delete();
        sxe = (sx == 0) ? 1 : sx;
        sye = (sy == 0) ? 1 : sy;
        cur_p = p;
        if (w == 0 || h == 0) return;
        for (int y = p; y <= p + h - 1; y += sye)
            for (int x = p; x <= p + w - 1; x += sxe) begin
                qx.push_back(x);
                qy.push_back(y);
            end
    endtask

    task automatic check_reset_state();
        check("rst_valid", pif.alloc_valid, 0);
        check("rst_index", pif.alloc_index, 0);
        check("rst_cx", pif.center_x, 0);
        check("rst_cy", pif.center_y, 0);
        check("rst_xmin", x_min, 8'hff);
        check("rst_xmax", x_max, 0);
        check("rst_ymin", y_min, 8'hff);
        check("rst_ymax", y_max, 0);
        check("rst_active", round_active, 0);
        check("rst_rdone", round_done, 0);
        check("rst_ldone", layer_done, 0);
        check("rst_rcount", round_count, 0);
    endtask

    task automatic load_cfg(input int w, input int h, input int p, input int sx, input int sy);
        image_w  = CW'(w);
        image_h  = CW'(h);
        padding  = PW'(p);
        stride_x = SW'(sx);
        stride_y = SW'(sy);
        cfg_load = 1'b1;
        advance  = 1'b0;
        pif.alloc_stall = 1'b0;
        @(negedge clk);
        cfg_load = 1'b0;
        check("cfg_valid", pif.alloc_valid, 0);
        check("cfg_active", round_active, 0);
        check("cfg_ldone", layer_done, 0);
        check("cfg_rcount", round_count, 0);
        check("cfg_cx", pif.center_x, p);
        check("cfg_cy", pif.center_y, p);
        check("cfg_xmin", x_min, 8'hff);
        check("cfg_ymax", y_max, 0);
        build_model(w, h, p, sx, sy);
        exp_rc = 0;
    endtask

    // mode 0: no stall, 1: random stall and stray advance, 2: three stalls at index 2
    task automatic run_rounds(input int max_acc, input int mode);
        int acc, n, placed, stalls, budget;
        int exmin, exmax, eymin, eymax;
        logic st;
        acc = 0;
        while (qx.size() > 0 && acc < max_acc) begin
            repeat ($urandom_range(0, 2)) begin
                check("wait_valid", pif.alloc_valid, 0);
                @(negedge clk);
            end
            advance = 1'b1;
            @(negedge clk);
            advance = 1'b0;
            check("round_active", round_active, 1);
            n = (qx.size() < NA) ? qx.size() : NA;
            placed = 0; stalls = 0; budget = 0;
            exmin = 255; exmax = 0; eymin = 255; eymax = 0;
            while (placed < n && acc < max_acc) begin
                check("alloc_valid", pif.alloc_valid, 1);
                check("center_x", pif.center_x, qx[0]);
                check("center_y", pif.center_y, qy[0]);
                check("alloc_index", pif.alloc_index, placed);
                if (mode == 1)      st = ($urandom_range(0, 2) == 0);
                else if (mode == 2) st = (placed == 2 && stalls < 3);
                else                st = 1'b0;
                if (st) stalls++;
                if (mode == 1) advance = ($urandom_range(0, 3) == 0);
                pif.alloc_stall = st;
`ifdef POSITIONER_ONEHOT_SELECT_EN
                #1 check("alloc_select", alloc_select, st ? 0 : (1 << placed));
`endif
                if (!st) begin
                    if (qx[0] - cur_p < exmin) exmin = qx[0] - cur_p;
                    if (qx[0] + cur_p > exmax) exmax = qx[0] + cur_p;
                    if (qy[0] - cur_p < eymin) eymin = qy[0] - cur_p;
                    if (qy[0] + cur_p > eymax) eymax = qy[0] + cur_p;
                    void'(qx.pop_front());
                    void'(qy.pop_front());
                    placed++;
                    acc++;
                end
                budget++;
                if (budget > 200) begin
                    check("place_timeout", placed, n);
                    pif.alloc_stall = 1'b0;
                    advance = 1'b0;
                    return;
                end
                @(negedge clk);
            end
            pif.alloc_stall = 1'b0;
            advance = 1'b0;
            if (placed == n) begin
                exp_rc++;
                check("round_done", round_done, 1);
                check("valid_after_round", pif.alloc_valid, 0);
                check("round_count", round_count, exp_rc);
                check("layer_done", layer_done, qx.size() == 0);
                check("bbox_xmin", x_min, exmin);
                check("bbox_xmax", x_max, exmax);
                check("bbox_ymin", y_min, eymin);
                check("bbox_ymax", y_max, eymax);
                @(negedge clk);
                check("round_done_pulse", round_done, 0);
            end
        end
    endtask

    task automatic check_done_hold();
        advance = 1'b1;
        @(negedge clk);
        advance = 1'b0;
        @(negedge clk);
        check("done_valid", pif.alloc_valid, 0);
        check("done_ldone", layer_done, 1);
        check("done_rcount", round_count, exp_rc);
        check("done_active", round_active, 0);
        check("done_rdone", round_done, 0);
    endtask

    initial begin
        rst = 1'b1; cfg_load = 1'b0; advance = 1'b0;
        image_w = '0; image_h = '0; padding = '0; stride_x = '0; stride_y = '0;
        pif.alloc_stall = 1'b0;
        exp_rc = 0;
        @(negedge clk);
        check_reset_state();
        rst = 1'b0;
        @(negedge clk);

        // zeroed config after reset: advance goes straight to a finished layer
        advance = 1'b1;
        @(negedge clk);
        advance = 1'b0;
        check("zcfg_ldone", layer_done, 1);
        check("zcfg_valid", pif.alloc_valid, 0);
        @(negedge clk);
        check("zcfg_rdone", round_done, 0);

        load_cfg(4, 4, 1, 1, 1);
        run_rounds(1000, 0);
        check_done_hold();

        load_cfg(5, 5, 0, 2, 2);
        run_rounds(1000, 0);
        check_done_hold();

        load_cfg(4, 4, 1, 1, 1);
        run_rounds(1000, 2);
        check_done_hold();

        load_cfg(4, 4, 1, 1, 1);
        run_rounds(3, 1);
        load_cfg(3, 3, 1, 1, 1);
        run_rounds(1000, 0);
        check_done_hold();

        load_cfg(6, 4, 2, 2, 1);
        run_rounds(3, 0);
        #2 rst = 1'b1;
        #1 check_reset_state();
        @(negedge clk);
        rst = 1'b0;
        check_reset_state();

        load_cfg(4, 0, 1, 1, 1);
        advance = 1'b1;
        @(negedge clk);
        advance = 1'b0;
        check("h0_valid", pif.alloc_valid, 0);
        check("h0_ldone", layer_done, 1);
        check("h0_rdone", round_done, 0);
        @(negedge clk);
        check("h0_rdone2", round_done, 0);
        check("h0_rcount", round_count, 0);
        check_done_hold();

        load_cfg(3, 2, 0, 0, 0);
        run_rounds(1000, 1);
        check_done_hold();

        for (int i = 0; i < 6; i++) begin
            load_cfg($urandom_range(1, 9), $urandom_range(1, 6), $urandom_range(0, 3),
                     $urandom_range(0, 4), $urandom_range(0, 4));
            run_rounds(1000, 1);
            check_done_hold();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
